studio_keypad_scan: RTL

- Parametrised keypad front end for the Studio II family. Replaces the single-pad, last-key-only decoder.
- Tracks make/break state per key for 1-2 hex/decimal keypads from PS/2 events.
- Holds a CPU-written key-select latch (OUT on a configurable N port) and drives the active-low EF3/EF4-style flags per pad.
- Sits between the PS/2 input and the CDP1802 EF inputs in the system top.

---
 rtl/studio_keypad_scan.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/studio_keypad_scan.sv
// Studio II keypad front end: per-key make/break tracking from PS/2 events,
// a CPU-loaded key-select latch and active-low "selected key down" flags.
//   clk_sys   system clock
//   reset     synchronous active-high reset
//   ps2_key   [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   io_n      CPU N lines;  io_out  OUT strobe;  cpu_dout  OUT data
//   ef_n      per-pad active-low flag (pad0 -> EF3, pad1 -> EF4)
//   key_sel   select latch
//   key_held  held bitmap, pad p key k at bit p*NUM_KEYS+k
//   key_any   OR of key_held
module studio_keypad_scan #(
   parameter int unsigned NUM_PADS = 2,
   parameter int unsigned NUM_KEYS = 10,
   parameter int unsigned SEL_PORT = 2,
   parameter int unsigned STRETCH  = 4096
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [10:0]                  ps2_key,
   input  logic [2:0]                   io_n,
   input  logic                         io_out,
   input  logic [7:0]                   cpu_dout,
   output logic [NUM_PADS-1:0]          ef_n,
   output logic [3:0]                   key_sel,
   output logic [NUM_PADS*NUM_KEYS-1:0] key_held,
   output logic                         key_any
);

   localparam int unsigned HW = NUM_PADS * NUM_KEYS;
   localparam int unsigned IW = (HW > 1) ? $clog2(HW) : 1;
   localparam int unsigned CW = (STRETCH > 2) ? $clog2(STRETCH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (STRETCH == 0) ? '0 : CW'(STRETCH - 1);
   localparam logic [4:0]    NK5      = 5'(NUM_KEYS);
   localparam logic [2:0]    SEL3     = 3'(SEL_PORT);

   logic                tog_q;
   logic [HW-1:0]       held_q, held_d;
   logic [NUM_PADS-1:0] busy_q, busy_d;
   logic [3:0]          pkey_q [NUM_PADS];
   logic [3:0]          pkey_d [NUM_PADS];
   logic [CW-1:0]       cnt_q  [NUM_PADS];
   logic [CW-1:0]       cnt_d  [NUM_PADS];
   logic [3:0]          sel_d;
   logic [NUM_PADS-1:0] ef_d;

   logic       evt;
   logic       dec_hit;
   logic       dec_pad;
   logic [3:0] dec_key;
   logic       key_ok;
   logic [IW-1:0] pad_base;
   logic [IW-1:0] ev_idx;
   logic       unused_dout;

   assign evt         = ps2_key[10] ^ tog_q;
   assign key_held    = held_q;
   assign unused_dout = ^cpu_dout[7:4];

   // Scancode to {pad, key}; extended bit is part of the match.
   always_comb begin
      dec_hit = 1'b1;
      {dec_pad, dec_key} = 5'h00;
      case (ps2_key[8:0])
         9'h045: {dec_pad, dec_key} = 5'h00;
         9'h016: {dec_pad, dec_key} = 5'h01;
         9'h01E: {dec_pad, dec_key} = 5'h02;
         9'h026: {dec_pad, dec_key} = 5'h03;
         9'h025: {dec_pad, dec_key} = 5'h04;
         9'h02E: {dec_pad, dec_key} = 5'h05;
         9'h036: {dec_pad, dec_key} = 5'h06;
         9'h03D: {dec_pad, dec_key} = 5'h07;
         9'h03E: {dec_pad, dec_key} = 5'h08;
         9'h046: {dec_pad, dec_key} = 5'h09;
         9'h01C: {dec_pad, dec_key} = 5'h0A;
         9'h032: {dec_pad, dec_key} = 5'h0B;
         9'h021: {dec_pad, dec_key} = 5'h0C;
         9'h023: {dec_pad, dec_key} = 5'h0D;
         9'h024: {dec_pad, dec_key} = 5'h0E;
         9'h02B: {dec_pad, dec_key} = 5'h0F;
         9'h070: {dec_pad, dec_key} = 5'h10;
         9'h069: {dec_pad, dec_key} = 5'h11;
         9'h072: {dec_pad, dec_key} = 5'h12;
         9'h07A: {dec_pad, dec_key} = 5'h13;
         9'h06B: {dec_pad, dec_key} = 5'h14;
         9'h073: {dec_pad, dec_key} = 5'h15;
         9'h074: {dec_pad, dec_key} = 5'h16;
         9'h06C: {dec_pad, dec_key} = 5'h17;
         9'h075: {dec_pad, dec_key} = 5'h18;
         9'h07D: {dec_pad, dec_key} = 5'h19;
         9'h14A: {dec_pad, dec_key} = 5'h1A;
         9'h07C: {dec_pad, dec_key} = 5'h1B;
         9'h07B: {dec_pad, dec_key} = 5'h1C;
         9'h079: {dec_pad, dec_key} = 5'h1D;
         9'h071: {dec_pad, dec_key} = 5'h1E;
         9'h15A: {dec_pad, dec_key} = 5'h1F;
         default: dec_hit = 1'b0;
      endcase
   end

   assign key_ok   = dec_hit && ({1'b0, dec_key} < NK5) && ((NUM_PADS > 1) || !dec_pad);
   assign pad_base = dec_pad ? IW'(NUM_KEYS) : IW'(0);
   assign ev_idx   = pad_base + IW'(dec_key);

   // Next state: stretch timers first, then the decoded event, so a make
   // of an expiring key still wins.
   always_comb begin
      held_d = held_q;
      busy_d = busy_q;
      pkey_d = pkey_q;
      cnt_d  = cnt_q;
      sel_d  = key_sel;
      ef_d   = '1;

      for (int p = 0; p < NUM_PADS; p++) begin
         if (busy_q[p]) begin
            if (cnt_q[p] == '0) begin
               held_d[IW'(p * NUM_KEYS) + IW'(pkey_q[p])] = 1'b0;
               busy_d[p] = 1'b0;
            end else begin
               cnt_d[p] = cnt_q[p] - CW'(1);
            end
         end
      end

      if (evt && key_ok) begin
         if (ps2_key[9]) begin
            held_d[ev_idx] = 1'b1;
            if (busy_q[dec_pad] && (pkey_q[dec_pad] == dec_key))
               busy_d[dec_pad] = 1'b0;
         end else if (held_q[ev_idx]) begin
            if (STRETCH == 0) begin
               held_d[ev_idx] = 1'b0;
            end else if (!busy_q[dec_pad] || (pkey_q[dec_pad] != dec_key)) begin
               // a second release on the same pad flushes the older one
               if (busy_q[dec_pad])
                  held_d[pad_base + IW'(pkey_q[dec_pad])] = 1'b0;
               busy_d[dec_pad] = 1'b1;
               pkey_d[dec_pad] = dec_key;
               cnt_d[dec_pad]  = CNT_LOAD;
            end
         end
      end

      if (io_out && (io_n == SEL3))
         sel_d = cpu_dout[3:0];

      // flags follow the registered state, one cycle behind it
      for (int p = 0; p < NUM_PADS; p++) begin
         if ({1'b0, key_sel} < NK5)
            ef_d[p] = ~held_q[IW'(p * NUM_KEYS) + IW'(key_sel)];
      end
   end

   // State registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tog_q   <= ps2_key[10];
         held_q  <= '0;
         busy_q  <= '0;
         for (int p = 0; p < NUM_PADS; p++) begin
            pkey_q[p] <= '0;
            cnt_q[p]  <= '0;
         end
         key_sel <= '0;
         ef_n    <= '1;
         key_any <= 1'b0;
      end else begin
         tog_q   <= ps2_key[10];
         held_q  <= held_d;
         busy_q  <= busy_d;
         pkey_q  <= pkey_d;
         cnt_q   <= cnt_d;
         key_sel <= sel_d;
         ef_n    <= ef_d;
         key_any <= |held_q;
      end
   end

endmodule
